bcd_converter_seq: RTL
======================

Name: bcd_converter_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Runs over IN_WIDTH clock cycles behind a start/busy/done handshake.
- Generalises the clock's combinational year decoder to any input width and digit count.
- Feeds the display digit registers for the year, day-count and future wide counters, and replaces long comparator chains with one small iterative datapath.

Parameters:
- IN_WIDTH, 10: binary input width; range 4..20.
- DIGITS, 3: number of BCD output digits; range 1..6.
- CNT_W, $clog2(IN_WIDTH+1): width of the internal step counter (derived; must not be overridden).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only while busy=0.
- din  input  IN_WIDTH  unsigned binary value; captured on the accepting edge.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; bcd_out and overflow are valid from this cycle.
- overflow  output  1  din was >= 10^DIGITS; held with the result.
- bcd_out  output  4*DIGITS  packed digits; [3:0] = ones, [7:4] = tens, and so on.

Behaviour:
- Reset: on a rising edge with rst=1:
  - state=IDLE, busy=0, done=0, overflow=0, bcd_out=0.
  - Shift register and step counter cleared.
  - rst overrides every other input, including mid-conversion; an in-flight conversion is discarded and no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: capture din into the shift register, clear the BCD scratch and the overflow flag, set counter=IN_WIDTH.
  - Go to SHIFT; busy=1 after that edge.
- SHIFT, one step per edge:
  - (a) Each scratch digit >= 5 gets +3; the adjustment is combinational within the step.
  - (b) Shift {scratch, shiftreg} left by 1.
  - (c) The bit shifted out of the top scratch digit ORs into the sticky overflow flag.
  - Decrement the counter. The edge that performs the step with counter==1 moves to DONE.
  - start is ignored throughout SHIFT.
- DONE, entered with busy=0 and done=1 for exactly one cycle:
  - bcd_out registered on the edge entering DONE.
  - If overflow=1, bcd_out is forced to all 4'h9 (saturate); otherwise bcd_out = scratch.
  - Next edge returns to IDLE. start=1 in the DONE cycle is accepted (back-to-back), with the same actions as in IDLE.
- Latency: start accepted at edge k gives done=1 and valid bcd_out after edge k+IN_WIDTH. Throughput is one conversion per IN_WIDTH+1 cycles.
- Output holding:
  - bcd_out and overflow hold their last values until the next DONE entry or reset.
  - bcd_out is not changed during SHIFT.
- Arithmetic:
  - All operations are unsigned. Digit values never exceed 9 after adjustment.
  - Scratch width is exactly 4*DIGITS; no hidden extra digit.
- Degenerate case: if IN_WIDTH <= 3*DIGITS, overflow is structurally impossible and the flag stays 0.
- din changing after the accepting edge has no effect.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- Defined:
  - In the DONE update, every digit above the ones digit that is zero and has only zero digits above it is replaced by 4'hF (blank code for the 7-segment driver).
  - The ones digit is never blanked.
  - Saturated output (overflow=1) is never blanked.
- Undefined: leading zeros are output as 4'h0; no blank logic is synthesised.

Test Plan:
- Default params, din=999, pulse start at edge k:
  - busy=1 for edges k+1..k+9 (until edge k+10).
  - done=1 only after edge k+10, with bcd_out=12'h999 and overflow=0.
- din=0, then din=1 back-to-back (start held through the DONE cycle):
  - Results 12'h000 then 12'h001, done pulses 11 cycles apart.
  - With BCD_LEADING_BLANK_EN: 12'hFF0 and 12'hFF1.
- din=1023 (default params): overflow=1, bcd_out=12'h999; the next conversion with din=42 gives overflow=0, bcd_out=12'h042.
- Start while busy: assert start with din=500 three cycles into a conversion of din=123. Result is 12'h123 and no extra done pulse occurs.
- Reset mid-operation: rst=1 at step 5 of a conversion:
  - All outputs 0, state IDLE, no done pulse.
  - A subsequent din=256 converts to 12'h256.
- IN_WIDTH=14, DIGITS=4:
  - din=9999 gives 16'h9999, done 14 edges after start.
  - din=10000 gives overflow=1, bcd_out=16'h9999.
  - Exhaustive sweep 0..9999 matches a reference model.

Source files
------------

// File: rtl/bcd_converter_seq.sv
// bcd_converter_seq: iterative binary-to-BCD converter (shift-and-add-3).
// One input bit is consumed per clock; a start/busy/done handshake frames
// each conversion.  Values that do not fit in DIGITS decimal digits
// saturate to all nines and raise overflow.
// Optional build macro: BCD_LEADING_BLANK_EN -- replaces leading zero
// digits (never the ones digit, never a saturated result) with 4'hF so
// the 7-segment driver shows them dark.
module bcd_converter_seq #(
  parameter int IN_WIDTH = 10,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   din,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out
);

  // Step counter must hold IN_WIDTH; derived here so it cannot be overridden.
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int SW    = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IN_WIDTH-1:0]  shift_q, shift_d;
  logic [SW-1:0]        scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;        // sticky flag while shifting
  logic                 overflow_q, overflow_d;
  logic [SW-1:0]        bcd_q, bcd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [SW-1:0]        adj_s;
  logic [SW-1:0]        step_scratch_s;
  logic [IN_WIDTH-1:0]  step_shift_s;
  logic                 step_ovf_s;

  // Add 3 to every digit that is 5 or more so the following doubling
  // carries correctly into the next decimal digit.
  function automatic logic [SW-1:0] add3_digits(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

`ifdef BCD_LEADING_BLANK_EN
  // Replace zero digits above the ones digit that have only zeros above
  // them with the blank code.
  function automatic logic [SW-1:0] blank_leading(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          seen_nz;
    r       = v;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (v[4*i +: 4] != 4'h0) begin
        seen_nz = 1'b1;
      end else begin
        seen_nz = seen_nz;
      end
      if (!seen_nz) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction
`endif

  // One double-dabble step: adjust, then shift {scratch, shiftreg} left.
  assign adj_s          = add3_digits(scratch_q);
  assign step_scratch_s = {adj_s[SW-2:0], shift_q[IN_WIDTH-1]};
  assign step_shift_s   = {shift_q[IN_WIDTH-2:0], 1'b0};
  assign step_ovf_s     = ovf_q | adj_s[SW-1];

  // Next-state, datapath and output decode.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    overflow_d = overflow_q;
    bcd_d      = bcd_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A start in the DONE cycle is accepted exactly as in IDLE.
        if (start) begin
          state_d   = S_SHIFT;
          shift_d   = din;
          scratch_d = '0;
          ovf_d     = 1'b0;
          cnt_d     = CNT_W'(IN_WIDTH);
          busy_d    = 1'b1;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_SHIFT: begin
        scratch_d = step_scratch_s;
        shift_d   = step_shift_s;
        ovf_d     = step_ovf_s;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          overflow_d = step_ovf_s;
          if (step_ovf_s) begin
            bcd_d = {DIGITS{4'h9}};
          end else begin
`ifdef BCD_LEADING_BLANK_EN
            bcd_d = blank_leading(step_scratch_s);
`else
            bcd_d = step_scratch_s;
`endif
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      overflow_q <= 1'b0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      overflow_q <= overflow_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign bcd_out  = bcd_q;

endmodule
